perceptron_predictor: RTL and testbench

PERCEPTRON_PREDICTOR -- requirements
Module: perceptron_predictor

---
 rtl/perceptron_predictor.sv | 146 ++++++++++++++
 tb/tb_perceptron_predictor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_predictor.sv
// Perceptron branch predictor: per-index signed weight vectors dotted with the
// global history. One-cycle registered prediction, same-cycle training on
// resolved branches, saturating update and mispredict counters.
module perceptron_predictor #(
   parameter int ADDRESS_LENGTH   = 64,
   parameter int NUM_PERCEPTRONS  = 64,
   parameter int HISTORY_LENGTH   = 64,
   parameter int PERCEPTRON_WIDTH = 8,
   parameter int THETA            = 137,
   parameter int COUNT_WIDTH      = 32,
   localparam int SUM_W = PERCEPTRON_WIDTH + $clog2(HISTORY_LENGTH + 1) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pred_valid,
   input  logic [ADDRESS_LENGTH-1:0] pred_addr,
   output logic                      pred_out_valid,
   output logic                      prediction,
   output logic signed [SUM_W-1:0]   pred_sum,
   input  logic                      upd_valid,
   input  logic [ADDRESS_LENGTH-1:0] upd_addr,
   input  logic                      b_taken,
   output logic [COUNT_WIDTH-1:0]    upd_count,
   output logic [COUNT_WIDTH-1:0]    mispred_count
);
   localparam int IDX_W = $clog2(NUM_PERCEPTRONS);
   localparam int NUM_W = HISTORY_LENGTH + 1;
   // Threshold compare is done wide enough that THETA never truncates.
   localparam int CMP_W = ((SUM_W > 32) ? SUM_W : 32) + 1;
   localparam logic signed [CMP_W-1:0] THETA_EXT = CMP_W'(THETA);
   localparam logic signed [PERCEPTRON_WIDTH-1:0] W_MAX = {1'b0, {(PERCEPTRON_WIDTH-1){1'b1}}};
   localparam logic signed [PERCEPTRON_WIDTH-1:0] W_MIN = {1'b1, {(PERCEPTRON_WIDTH-1){1'b0}}};

   // Weights live in flops: both ports read combinationally and reset clears all.
   logic signed [PERCEPTRON_WIDTH-1:0] weight_reg [NUM_PERCEPTRONS][NUM_W];
   logic [HISTORY_LENGTH-1:0]          ghr_reg;
   logic [COUNT_WIDTH-1:0]             upd_count_reg;
   logic [COUNT_WIDTH-1:0]             mispred_count_reg;
   logic                               pred_out_valid_reg;
   logic                               prediction_reg;
   logic signed [SUM_W-1:0]            pred_sum_reg;

   logic [IDX_W-1:0]                   pred_idx;
   logic [IDX_W-1:0]                   upd_idx;
   logic signed [SUM_W-1:0]            pred_term [NUM_W];
   logic signed [SUM_W-1:0]            upd_term [NUM_W];
   logic                               upd_inc [NUM_W];
   logic signed [PERCEPTRON_WIDTH-1:0] upd_w_next [NUM_W];
   logic signed [SUM_W-1:0]            pred_y;
   logic signed [SUM_W-1:0]            upd_y;
   logic signed [CMP_W-1:0]            upd_y_ext;
   logic                               upd_mispred;
   logic                               upd_train;
   logic                               addr_unused;

   assign pred_idx    = pred_addr[IDX_W-1:0];
   assign upd_idx     = upd_addr[IDX_W-1:0];
   assign addr_unused = ^{pred_addr, upd_addr};

   // Per-weight signed contributions for both ports, and the saturating
   // +/-1 step for the entry being trained (t*xi = +1 when outcome matches history bit).
   genvar gi;
   generate
      for (gi = 0; gi < NUM_W; gi++) begin : g_weight
         if (gi == 0) begin : g_bias
            assign pred_term[gi] = SUM_W'(weight_reg[pred_idx][gi]);
            assign upd_term[gi]  = SUM_W'(weight_reg[upd_idx][gi]);
            assign upd_inc[gi]   = b_taken;
         end else begin : g_hist
            assign pred_term[gi] = ghr_reg[gi-1] ? SUM_W'(weight_reg[pred_idx][gi])
                                                 : -SUM_W'(weight_reg[pred_idx][gi]);
            assign upd_term[gi]  = ghr_reg[gi-1] ? SUM_W'(weight_reg[upd_idx][gi])
                                                 : -SUM_W'(weight_reg[upd_idx][gi]);
            assign upd_inc[gi]   = (b_taken == ghr_reg[gi-1]);
         end
         assign upd_w_next[gi] = upd_inc[gi]
            ? ((weight_reg[upd_idx][gi] == W_MAX) ? W_MAX : weight_reg[upd_idx][gi] + PERCEPTRON_WIDTH'(1))
            : ((weight_reg[upd_idx][gi] == W_MIN) ? W_MIN : weight_reg[upd_idx][gi] - PERCEPTRON_WIDTH'(1));
      end
   endgenerate

   // Dot products for the prediction and update ports from pre-edge state.
   always_comb begin
      pred_y = '0;
      upd_y  = '0;
      for (int i = 0; i < NUM_W; i++) begin
         pred_y = pred_y + pred_term[i];
         upd_y  = upd_y + upd_term[i];
      end
   end

   // Training decision: mispredicted or not yet confident beyond THETA.
   always_comb begin
      upd_y_ext   = CMP_W'(upd_y);
      upd_mispred = (~upd_y[SUM_W-1]) != b_taken;
      upd_train   = upd_mispred || ((upd_y_ext <= THETA_EXT) && (upd_y_ext >= -THETA_EXT));
   end

   // Registered prediction output; value fields hold when no request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_out_valid_reg <= 1'b0;
         prediction_reg     <= 1'b0;
         pred_sum_reg       <= '0;
      end else begin
         pred_out_valid_reg <= pred_valid;
         if (pred_valid) begin
            prediction_reg <= ~pred_y[SUM_W-1];
            pred_sum_reg   <= pred_y;
         end
      end
   end

   // Global history shift and saturating statistics on every update.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_reg           <= '0;
         upd_count_reg     <= '0;
         mispred_count_reg <= '0;
      end else if (upd_valid) begin
         ghr_reg <= (ghr_reg << 1) | HISTORY_LENGTH'(b_taken);
         if (upd_count_reg != '1)
            upd_count_reg <= upd_count_reg + COUNT_WIDTH'(1);
         if (upd_mispred && (mispred_count_reg != '1))
            mispred_count_reg <= mispred_count_reg + COUNT_WIDTH'(1);
      end
   end

   // Weight table: full clear on reset, write back the trained entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NUM_PERCEPTRONS; n++)
            for (int i = 0; i < NUM_W; i++)
               weight_reg[n][i] <= '0;
      end else if (upd_valid && upd_train) begin
         for (int i = 0; i < NUM_W; i++)
            weight_reg[upd_idx][i] <= upd_w_next[i];
      end
   end

   assign pred_out_valid = pred_out_valid_reg;
   assign prediction     = prediction_reg;
   assign pred_sum       = pred_sum_reg;
   assign upd_count      = upd_count_reg;
   assign mispred_count  = mispred_count_reg;
endmodule

// File: tb/tb_perceptron_predictor.sv
// Bench for perceptron_predictor: three instances (THETA 21, THETA 100,
// 2-bit counters) share one stimulus stream and are compared to a model.
module tb_perceptron_predictor;
   localparam int AL = 8;
   localparam int SW = 8;
   localparam int THETA_K [3] = '{21, 100, 21};
   localparam int CMAX_K  [3] = '{255, 255, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, pred_valid, upd_valid, b_taken;
   logic [AL-1:0] pred_addr, upd_addr;

   logic                 pov_a, pp_a, pov_b, pp_b, pov_c, pp_c;
   logic signed [SW-1:0] ps_a, ps_b, ps_c;
   logic [7:0]           uc_a, mc_a, uc_b, mc_b;
   logic [1:0]           uc_c, mc_c;

   perceptron_predictor #(.ADDRESS_LENGTH(AL), .NUM_PERCEPTRONS(4), .HISTORY_LENGTH(4),
      .PERCEPTRON_WIDTH(4), .THETA(21), .COUNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_addr(pred_addr),
      .pred_out_valid(pov_a), .prediction(pp_a), .pred_sum(ps_a),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .b_taken(b_taken),
      .upd_count(uc_a), .mispred_count(mc_a));

   perceptron_predictor #(.ADDRESS_LENGTH(AL), .NUM_PERCEPTRONS(4), .HISTORY_LENGTH(4),
      .PERCEPTRON_WIDTH(4), .THETA(100), .COUNT_WIDTH(8)) dut_b (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_addr(pred_addr),
      .pred_out_valid(pov_b), .prediction(pp_b), .pred_sum(ps_b),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .b_taken(b_taken),
      .upd_count(uc_b), .mispred_count(mc_b));

   perceptron_predictor #(.ADDRESS_LENGTH(AL), .NUM_PERCEPTRONS(4), .HISTORY_LENGTH(4),
      .PERCEPTRON_WIDTH(4), .THETA(21), .COUNT_WIDTH(2)) dut_c (
      .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_addr(pred_addr),
      .pred_out_valid(pov_c), .prediction(pp_c), .pred_sum(ps_c),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .b_taken(b_taken),
      .upd_count(uc_c), .mispred_count(mc_c));

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic            v;
      logic [2:0]      p;
      logic [2:0][7:0] s;
      logic [2:0][7:0] u;
      logic [2:0][7:0] m;
   } exp_t;
   exp_t sb[$];

   // Reference model state (plain integers)
   int mw [3][4][5];
   int mghr [3];
   int mupd [3];
   int mmis [3];
   int hs [3];
   bit hp [3];

   function automatic int clamp(input int v);
      if (v > 7) return 7;
      if (v < -8) return -8;
      return v;
   endfunction

   function automatic int msum(input int k, input int idx);
      int y;
      y = mw[k][idx][0];
      for (int i = 1; i <= 4; i++)
         y += (((mghr[k] >> (i - 1)) & 1) != 0) ? mw[k][idx][i] : -mw[k][idx][i];
      return y;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic get_obs(input int k, output logic v, output logic p, output logic [7:0] s,
                          output logic [7:0] u, output logic [7:0] m);
      case (k)
         0: begin v = pov_a; p = pp_a; s = ps_a; u = uc_a; m = mc_a; end
         1: begin v = pov_b; p = pp_b; s = ps_b; u = uc_b; m = mc_b; end
         default: begin v = pov_c; p = pp_c; s = ps_c; u = {6'd0, uc_c}; m = {6'd0, mc_c}; end
      endcase
   endtask

   // One clock: drive inputs, advance the model, push expectation, then compare.
   task automatic cyc(input bit r, input bit pv, input int pa, input bit uv, input int ua, input bit bt);
      exp_t e;
      int y, t, x, ia, iu;
      logic v, p;
      logic [7:0] s, u, m;
      rst = r; pred_valid = pv; pred_addr = AL'(pa);
      upd_valid = uv; upd_addr = AL'(ua); b_taken = bt;
      ia = pa & 3;
      iu = ua & 3;
      e = '0;
      e.v = !r && pv;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            for (int n = 0; n < 4; n++)
               for (int i = 0; i < 5; i++) mw[k][n][i] = 0;
            mghr[k] = 0; mupd[k] = 0; mmis[k] = 0; hs[k] = 0; hp[k] = 0;
         end else begin
            if (pv) begin
               hs[k] = msum(k, ia);
               hp[k] = (hs[k] >= 0);
            end
            if (uv) begin
               y = msum(k, iu);
               if ((y >= 0) != bt) begin
                  if (mmis[k] < CMAX_K[k]) mmis[k]++;
               end
               if (((y >= 0) != bt) || (y <= THETA_K[k] && y >= -THETA_K[k])) begin
                  t = bt ? 1 : -1;
                  mw[k][iu][0] = clamp(mw[k][iu][0] + t);
                  for (int i = 1; i <= 4; i++) begin
                     x = (((mghr[k] >> (i - 1)) & 1) != 0) ? 1 : -1;
                     mw[k][iu][i] = clamp(mw[k][iu][i] + t * x);
                  end
               end
               mghr[k] = ((mghr[k] << 1) | int'(bt)) & 15;
               if (mupd[k] < CMAX_K[k]) mupd[k]++;
            end
         end
         e.p[k] = hp[k];
         e.s[k] = 8'(hs[k]);
         e.u[k] = 8'(mupd[k]);
         e.m[k] = 8'(mmis[k]);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         get_obs(k, v, p, s, u, m);
         chk($sformatf("dut%0d.valid", k), {31'd0, v}, {31'd0, e.v});
         chk($sformatf("dut%0d.prediction", k), {31'd0, p}, {31'd0, e.p[k]});
         chk($sformatf("dut%0d.pred_sum", k), {24'd0, s}, {24'd0, e.s[k]});
         chk($sformatf("dut%0d.upd_count", k), {24'd0, u}, {24'd0, e.u[k]});
         chk($sformatf("dut%0d.mispred_count", k), {24'd0, m}, {24'd0, e.m[k]});
      end
      $display("cycle rst=%0b pv=%0b pa=%0d uv=%0b ua=%0d bt=%0b -> a:%0b/%0b/%0d b:%0b/%0b/%0d c:%0b/%0b/%0d",
               r, pv, pa, uv, ua, bt, pov_a, pp_a, ps_a, pov_b, pp_b, ps_b, pov_c, pp_c, ps_c);
   endtask

   initial begin
      rst = 1'b1; pred_valid = 1'b0; upd_valid = 1'b0; b_taken = 1'b0;
      pred_addr = '0; upd_addr = '0;

      // Reset state
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      // First request after reset predicts taken with zero sum
      cyc(0, 1, 0, 0, 0, 0);
      chk("first_pred.valid", {31'd0, pov_a}, 32'd1);
      chk("first_pred.taken", {31'd0, pp_a}, 32'd1);
      chk("first_pred.sum", {24'd0, ps_a}, 32'd0);

      // Six not-taken updates on entry 1; training stops after five at THETA=21
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 1, 1, 0, 0, 0);
      chk("train_stop.sum", {24'd0, ps_a}, 32'(8'hE7));
      chk("train_stop.pred", {31'd0, pp_a}, 32'd0);
      chk("train_stop.upd_count", {24'd0, uc_a}, 32'd6);
      chk("train_stop.mispred_count", {24'd0, mc_a}, 32'd1);

      // Fourteen more (twenty total): weights saturate at THETA=100
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, 1, 0);
      cyc(0, 1, 1, 0, 0, 0);
      chk("saturate.sum", {24'd0, ps_b}, 32'(8'hDC));
      chk("no_retrain.sum", {24'd0, ps_a}, 32'(8'hE7));

      // Same-cycle predict and update on one index: read-before-write
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 2, 1, 2, 1);
      chk("rbw.sum", {24'd0, ps_a}, 32'd0);
      cyc(0, 1, 2, 0, 0, 0);
      chk("rbw_after.sum", {24'd0, ps_a}, 32'd3);

      // Reset dominates simultaneous predict and update
      cyc(0, 0, 0, 1, 3, 1);
      cyc(1, 1, 3, 1, 3, 1);
      chk("rst_dom.valid", {31'd0, pov_a}, 32'd0);
      chk("rst_dom.upd_count", {24'd0, uc_a}, 32'd0);
      cyc(0, 1, 3, 0, 0, 0);
      chk("rst_dom.weights", {24'd0, ps_a}, 32'd0);

      // Five mispredicting updates: 2-bit counter holds at 3
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, i, 0);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("cnt_sat.mispred_c", {30'd0, mc_c}, 32'd3);
      chk("cnt_sat.mispred_a", {24'd0, mc_a}, 32'd5);

      // Mixed random traffic against the model
      for (int i = 0; i < 40; i++)
         cyc(($urandom_range(0, 15) == 0), 1'($urandom), int'($urandom_range(0, 255)),
             1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
